// File: rtl/memwb_stage_reg.sv
// MEM/WB pipeline stage register with valid/ready handshake, flush, sticky halt and retire counter.
// Define MEMWB_SKID_EN to build a two-entry skid buffer with a registered in_ready.
module memwb_stage_reg #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32,
    parameter int RWIDTH = 5,
    parameter int CNTW   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic [1:0]        memtoregin,
    input  logic              regwrin,
    input  logic              finin,
    input  logic [RWIDTH-1:0] regdstmuxin,
    input  logic [DWIDTH-1:0] aluoutin,
    input  logic [DWIDTH-1:0] dmdatain,
    input  logic [AWIDTH-1:0] pcnextin,
    input  logic              negativein,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        memtoregout,
    output logic              regwrout,
    output logic              finout,
    output logic [RWIDTH-1:0] regdstmuxout,
    output logic [DWIDTH-1:0] aluoutout,
    output logic [DWIDTH-1:0] dmdataout,
    output logic [AWIDTH-1:0] pcnextout,
    output logic              negativeout,
    output logic              halted,
    output logic [CNTW-1:0]   retire_cnt
);

    localparam int BW = 2 + 1 + 1 + RWIDTH + 2 * DWIDTH + AWIDTH + 1;

    logic [BW-1:0]     in_beat;
    logic [BW-1:0]     main_d;
    logic [BW-1:0]     main_p0;
    logic              vld_p0;
    logic              accept;
    logic              retire;
    logic              load_main;
    logic              halted_q;
    logic [CNTW-1:0]   cnt_q;

    logic [1:0]        memtoreg_p0;
    logic              regwr_p0;
    logic              fin_p0;
    logic [RWIDTH-1:0] regdst_p0;
    logic [DWIDTH-1:0] aluout_p0;
    logic [DWIDTH-1:0] dmdata_p0;
    logic [AWIDTH-1:0] pcnext_p0;
    logic              negative_p0;

    assign in_beat = {memtoregin, regwrin, finin, regdstmuxin, aluoutin, dmdatain, pcnextin, negativein};
    assign {memtoreg_p0, regwr_p0, fin_p0, regdst_p0, aluout_p0, dmdata_p0, pcnext_p0, negative_p0} = main_p0;

    assign accept = in_valid && in_ready;
    assign retire = vld_p0 && out_ready;

`ifdef MEMWB_SKID_EN
    typedef enum logic [1:0] {EMPTY, MAIN, BOTH} state_t;

    state_t        state_q;
    state_t        state_d;
    logic          ready_q;
    logic          ready_d;
    logic          load_skid;
    logic          main_from_skid;
    logic [BW-1:0] skid_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
        end
    end

    // in_ready is precomputed for the next cycle so it never depends on out_ready combinationally
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (accept) state_d = MAIN;
            MAIN:    if (accept && !retire) state_d = BOTH;
                     else if (!accept && retire) state_d = EMPTY;
            BOTH:    if (retire) state_d = MAIN;
            default: state_d = EMPTY;
        endcase
        if (flush) state_d = EMPTY;
        ready_d = !(halted_q || (retire && fin_p0)) && (state_d != BOTH);
    end

    always_comb begin
        vld_p0         = (state_q != EMPTY);
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        if (!flush) begin
            case (state_q)
                EMPTY:   load_main = accept;
                MAIN:    begin
                    load_main = accept && retire;
                    load_skid = accept && !retire;
                end
                BOTH:    begin
                    load_main      = retire;
                    main_from_skid = retire;
                end
                default: load_main = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         skid_p1 <= '0;
        else if (load_skid) skid_p1 <= in_beat;
    end

    assign in_ready = ready_q;
    assign main_d   = main_from_skid ? skid_p1 : in_beat;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      vld_p0 <= 1'b0;
        else if (flush)  vld_p0 <= 1'b0;
        else if (accept) vld_p0 <= 1'b1;
        else if (retire) vld_p0 <= 1'b0;
    end

    assign in_ready  = !halted_q && (!vld_p0 || out_ready);
    assign load_main = accept && !flush;
    assign main_d    = in_beat;
`endif

    // MEM -> WB boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         main_p0 <= '0;
        else if (load_main) main_p0 <= main_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else if (retire) begin
            cnt_q <= cnt_q + 1'b1;
            if (fin_p0) halted_q <= 1'b1;
        end
    end

    assign out_valid    = vld_p0;
    assign regwrout     = regwr_p0 & vld_p0;
    assign finout       = fin_p0 & vld_p0;
    assign memtoregout  = memtoreg_p0;
    assign regdstmuxout = regdst_p0;
    assign aluoutout    = aluout_p0;
    assign dmdataout    = dmdata_p0;
    assign pcnextout    = pcnext_p0;
    assign negativeout  = negative_p0;
    assign halted       = halted_q;
    assign retire_cnt   = cnt_q;

endmodule

// File: tb/tb_memwb_stage_reg.sv
// Randomized bench for memwb_stage_reg against a queue-based model of the MEM/WB stage.
`timescale 1ns/1ps
module tb_memwb_stage_reg;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int RW = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, flush;
    logic [1:0]    memtoregin;
    logic          regwrin, finin, negativein;
    logic [RW-1:0] regdstmuxin;
    logic [DW-1:0] aluoutin, dmdatain;
    logic [AW-1:0] pcnextin;
    logic          out_valid, out_ready;
    logic [1:0]    memtoregout;
    logic          regwrout, finout, negativeout, halted;
    logic [RW-1:0] regdstmuxout;
    logic [DW-1:0] aluoutout, dmdataout;
    logic [AW-1:0] pcnextout;
    logic [CW-1:0] retire_cnt;

    always #5 clk = ~clk;

    memwb_stage_reg #(.DWIDTH(DW), .AWIDTH(AW), .RWIDTH(RW), .CNTW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .memtoregin(memtoregin), .regwrin(regwrin), .finin(finin), .regdstmuxin(regdstmuxin),
        .aluoutin(aluoutin), .dmdatain(dmdatain), .pcnextin(pcnextin), .negativein(negativein),
        .out_valid(out_valid), .out_ready(out_ready), .memtoregout(memtoregout),
        .regwrout(regwrout), .finout(finout), .regdstmuxout(regdstmuxout),
        .aluoutout(aluoutout), .dmdataout(dmdataout), .pcnextout(pcnextout),
        .negativeout(negativeout), .halted(halted), .retire_cnt(retire_cnt)
    );

    typedef struct packed {
        logic [1:0]    m2r;
        logic          rw;
        logic          fin;
        logic [RW-1:0] rd;
        logic [DW-1:0] alu;
        logic [DW-1:0] dm;
        logic [AW-1:0] pc;
        logic          neg;
    } beat_t;

    // Reference model: ordered list of held beats plus last-presented beat.
    beat_t         mq[$];
    beat_t         mlast;
    logic          mhalt;
    logic [CW-1:0] mcnt;

    int            n_chk = 0;
    int            n_pass = 0;
    logic [DW-1:0] obs[$];
    int            fin_pulses;
    logic          s_rdy, s_ov, s_rw, s_halt;
    logic [CW-1:0] s_cnt;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    function automatic logic model_ready(input logic ordy);
`ifdef MEMWB_SKID_EN
        return !mhalt && (mq.size() < 2);
`else
        return !mhalt && (mq.size() == 0 || ordy);
`endif
    endfunction

    function automatic beat_t rnd_beat();
        logic [127:0] r;
        beat_t        b;
        r = {$urandom, $urandom, $urandom, $urandom};
        b = r[$bits(beat_t)-1:0];
        b.fin = 1'b0;
        return b;
    endfunction

    task automatic model_reset();
        mq.delete();
        mlast = '0;
        mhalt = 1'b0;
        mcnt  = '0;
    endtask

    task automatic cycle(input logic iv, input beat_t b, input logic ordy, input logic fl, output logic acc);
        logic  exp_rdy, ov, ret;
        beat_t e;
        @(negedge clk);
        in_valid = iv;
        {memtoregin, regwrin, finin, regdstmuxin, aluoutin, dmdatain, pcnextin, negativein} = b;
        out_ready = ordy;
        flush = fl;
        #1;
        exp_rdy = model_ready(ordy);
        ov = (mq.size() != 0);
        e = mlast;
        chk("in_ready",     64'(in_ready),     64'(exp_rdy));
        chk("out_valid",    64'(out_valid),    64'(ov));
        chk("regwrout",     64'(regwrout),     64'(ov & e.rw));
        chk("finout",       64'(finout),       64'(ov & e.fin));
        chk("memtoregout",  64'(memtoregout),  64'(e.m2r));
        chk("regdstmuxout", 64'(regdstmuxout), 64'(e.rd));
        chk("aluoutout",    64'(aluoutout),    64'(e.alu));
        chk("dmdataout",    64'(dmdataout),    64'(e.dm));
        chk("pcnextout",    64'(pcnextout),    64'(e.pc));
        chk("negativeout",  64'(negativeout),  64'(e.neg));
        chk("halted",       64'(halted),       64'(mhalt));
        chk("retire_cnt",   64'(retire_cnt),   64'(mcnt));
        s_rdy = in_ready; s_ov = out_valid; s_rw = regwrout; s_halt = halted; s_cnt = retire_cnt;
        if (out_valid && ordy) obs.push_back(aluoutout);
        if (finout) fin_pulses++;
        @(posedge clk);
        acc = iv && exp_rdy;
        ret = ov && ordy;
        if (ret) begin
            mcnt = mcnt + 1'b1;
            if (mq[0].fin) mhalt = 1'b1;
            void'(mq.pop_front());
        end
        if (fl) mq.delete();
        else if (acc) mq.push_back(b);
        if (mq.size() != 0) mlast = mq[0];
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b1; regwrin = 1'b1; out_ready = 1'b1; flush = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid),  64'(0));
        chk("rst_regwrout",  64'(regwrout),   64'(0));
        chk("rst_cnt",       64'(retire_cnt), 64'(0));
        chk("rst_halted",    64'(halted),     64'(0));
        in_valid = 1'b0;
        rst_n = 1'b1;
        model_reset();
        #1;
        chk("rst_in_ready",  64'(in_ready),   64'(1));
    endtask

    initial begin
        beat_t b, pend;
        logic  acc, have;
        int    idx, leaks;

        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        memtoregin = '0; regwrin = 1'b0; finin = 1'b0; regdstmuxin = '0;
        aluoutin = '0; dmdatain = '0; pcnextin = '0; negativein = 1'b0;
        model_reset();
        fin_pulses = 0;
        do_reset();

        // Streaming at full throughput
        obs.delete();
        for (int i = 1; i <= 8; i++) begin
            b = '0; b.alu = DW'(i); b.rd = 5'd3; b.rw = 1'b1;
            cycle(1'b1, b, 1'b1, 1'b0, acc);
        end
        cycle(1'b0, '0, 1'b1, 1'b0, acc);
        cycle(1'b0, '0, 1'b1, 1'b0, acc);
        chk("stream_cnt", 64'(s_cnt), 64'(8));
        chk("stream_len", 64'(obs.size()), 64'(8));
        for (int i = 0; i < 8 && i < obs.size(); i++)
            chk("stream_order", 64'(obs[i]), 64'(i + 1));

        // Backpressure with two offered beats
        obs.delete();
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            b = '0; b.alu = (idx == 0) ? 32'hA : 32'hB;
            cycle(idx < 2, b, c >= 3, 1'b0, acc);
            if (acc) idx++;
`ifdef MEMWB_SKID_EN
            if (c == 1) chk("bp_ready_c1", 64'(s_rdy), 64'(1));
`else
            if (c == 1) chk("bp_ready_c1", 64'(s_rdy), 64'(0));
`endif
            if (c == 2) chk("bp_ready_c2", 64'(s_rdy), 64'(0));
        end
        chk("bp_len", 64'(obs.size()), 64'(2));
        if (obs.size() >= 2) begin
            chk("bp_first",  64'(obs[0]), 64'(32'hA));
            chk("bp_second", 64'(obs[1]), 64'(32'hB));
        end

        // Flush with a held beat and with an offer into an empty stage
        obs.delete();
        b = '0; b.alu = 32'h55; b.rw = 1'b1;
        cycle(1'b1, b, 1'b0, 1'b0, acc);
        cycle(1'b0, '0, 1'b0, 1'b0, acc);
        b.alu = 32'h66;
        cycle(1'b1, b, 1'b0, 1'b1, acc);
        cycle(1'b0, '0, 1'b1, 1'b0, acc);
        chk("flush_ov", 64'(s_ov), 64'(0));
        chk("flush_rw", 64'(s_rw), 64'(0));
        b.alu = 32'h77;
        cycle(1'b1, b, 1'b1, 1'b1, acc);
        cycle(1'b0, '0, 1'b1, 1'b0, acc);
        chk("flush_empty_ov", 64'(s_ov), 64'(0));
        chk("flush_cnt", 64'(s_cnt), 64'(10));
        leaks = 0;
        foreach (obs[i]) if (obs[i] == 32'h66 || obs[i] == 32'h77) leaks++;
        chk("flush_leak", 64'(leaks), 64'(0));

        // Randomized traffic, source holds an unaccepted beat
        have = 1'b0; pend = '0;
        for (int c = 0; c < 400; c++) begin
            if (!have) begin
                pend = rnd_beat();
                have = (($urandom % 4) != 0);
            end
            cycle(have, pend, ($urandom % 3) != 0, ($urandom % 30) == 0, acc);
            if (acc) have = 1'b0;
        end

        // Sticky halt on a retiring fin beat
        do_reset();
        fin_pulses = 0;
        b = '0; b.alu = 32'hF1; b.fin = 1'b1;
        cycle(1'b1, b, 1'b1, 1'b0, acc);
        cycle(1'b0, '0, 1'b1, 1'b0, acc);
        b = '0; b.alu = 32'hF2; b.rw = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cycle(1'b1, b, 1'b1, 1'b0, acc);
            chk("halt_ready", 64'(s_rdy), 64'(0));
            chk("halt_flag",  64'(s_halt), 64'(1));
            chk("halt_cnt",   64'(s_cnt), 64'(1));
        end
        chk("fin_pulses", 64'(fin_pulses), 64'(1));

        // Retire counter wrap
        do_reset();
        for (int i = 0; i < 15; i++) begin
            b = rnd_beat();
            cycle(1'b1, b, 1'b1, 1'b0, acc);
        end
        cycle(1'b0, '0, 1'b1, 1'b0, acc);
        cycle(1'b0, '0, 1'b1, 1'b0, acc);
        chk("wrap_pre", 64'(s_cnt), 64'(15));
        b = rnd_beat();
        cycle(1'b1, b, 1'b1, 1'b0, acc);
        cycle(1'b0, '0, 1'b1, 1'b0, acc);
        cycle(1'b0, '0, 1'b1, 1'b0, acc);
        chk("wrap", 64'(s_cnt), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
